// File: rtl/regfile_writeback_arbiter_if.sv
// Writeback bus between the three result producers (load, ALU, mul/div)
// and the register-file write-port arbiter.
//   slave  : arbiter side - takes requests, returns ready, drives write ports
//   master : requester / environment side
// Signals:
//   <req>_valid/_addr/_data : writeback request (req = ld, alu, md)
//   <req>_ready             : request accepted this cycle
//   write_enable/addr/data_c, _d : registered register-file write ports
//   pending_mask            : registers with a waiting or in-flight write
interface regfile_writeback_arbiter_if;
    logic        ld_valid;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        md_valid;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        md_ready;
    logic        write_enable_c;
    logic [4:0]  write_addr_c;
    logic [31:0] write_data_c;
    logic        write_enable_d;
    logic [4:0]  write_addr_d;
    logic [31:0] write_data_d;
    logic [31:0] pending_mask;

    modport slave (
        input  ld_valid, ld_addr, ld_data, alu_valid, alu_addr, alu_data,
               md_valid, md_addr, md_data,
        output ld_ready, alu_ready, md_ready,
               write_enable_c, write_addr_c, write_data_c,
               write_enable_d, write_addr_d, write_data_d, pending_mask
    );

    modport master (
        output ld_valid, ld_addr, ld_data, alu_valid, alu_addr, alu_data,
               md_valid, md_addr, md_data,
        input  ld_ready, alu_ready, md_ready,
               write_enable_c, write_addr_c, write_data_c,
               write_enable_d, write_addr_d, write_data_d, pending_mask
    );
endinterface

// File: rtl/regfile_writeback_arbiter.sv
// Register-file writeback arbiter.
// Shares write ports c and d between load, ALU and mul/div results. Up to two
// port-consuming grants per cycle, fixed priority ld > alu > md, with mul/div
// promoted to the top (md > ld > alu) after STARVE_LIMIT stalled cycles.
// Writes to register 0 are acknowledged but never use a port. Two grants in
// one cycle never target the same register. Write ports are registered
// (1-cycle latency); ready and pending_mask are combinational.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : regfile_writeback_arbiter_if.slave (requests, readies, write ports,
//           pending_mask)
module regfile_writeback_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic                         clk,
    input logic                         reset,
    regfile_writeback_arbiter_if.slave  bus
);

    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    // Requester index: 0 = ld, 1 = alu, 2 = md
    logic [2:0]  vld_s;
    logic [4:0]  addr_s [3];
    logic [31:0] data_s [3];

    logic [3:0]  starve_r;
    logic        promote_s;
    logic [1:0]  order_s [3];
    logic [1:0]  sel_s;
    logic [1:0]  used_s;
    logic [4:0]  first_addr_s;
    logic [2:0]  grant_s;

    logic        nxt_en_c_s;
    logic [4:0]  nxt_addr_c_s;
    logic [31:0] nxt_data_c_s;
    logic        nxt_en_d_s;
    logic [4:0]  nxt_addr_d_s;
    logic [31:0] nxt_data_d_s;

    logic        en_c_r;
    logic [4:0]  addr_c_r;
    logic [31:0] data_c_r;
    logic        en_d_r;
    logic [4:0]  addr_d_r;
    logic [31:0] data_d_r;

    logic [31:0] mask_s;

    // Gather the three requesters into indexable form.
    always_comb begin
        vld_s     = {bus.md_valid, bus.alu_valid, bus.ld_valid};
        addr_s[0] = bus.ld_addr;
        addr_s[1] = bus.alu_addr;
        addr_s[2] = bus.md_addr;
        data_s[0] = bus.ld_data;
        data_s[1] = bus.alu_data;
        data_s[2] = bus.md_data;
    end

    assign promote_s = (starve_r == LIMIT_C);

    // Priority order for this cycle; a starved mul/div jumps to the front.
    always_comb begin
        if (promote_s) begin
            order_s[0] = 2'd2;
            order_s[1] = 2'd0;
            order_s[2] = 2'd1;
        end else begin
            order_s[0] = 2'd0;
            order_s[1] = 2'd1;
            order_s[2] = 2'd2;
        end
    end

    // Grant walk in priority order: first port user goes to c, second to d.
    // A second user must not hit the same register as the first; address-0
    // requests are acknowledged without taking a port.
    always_comb begin
        grant_s      = 3'b000;
        used_s       = 2'd0;
        first_addr_s = 5'd0;
        sel_s        = 2'd0;
        nxt_en_c_s   = 1'b0;
        nxt_addr_c_s = 5'd0;
        nxt_data_c_s = 32'd0;
        nxt_en_d_s   = 1'b0;
        nxt_addr_d_s = 5'd0;
        nxt_data_d_s = 32'd0;
        if (!reset) begin
            for (int k = 0; k < 3; k++) begin
                sel_s = order_s[k];
                if (!vld_s[sel_s]) begin
                    grant_s[sel_s] = 1'b0;
                end else if (addr_s[sel_s] == 5'd0) begin
                    grant_s[sel_s] = 1'b1;
                end else if (used_s == 2'd0) begin
                    grant_s[sel_s] = 1'b1;
                    nxt_en_c_s     = 1'b1;
                    nxt_addr_c_s   = addr_s[sel_s];
                    nxt_data_c_s   = data_s[sel_s];
                    first_addr_s   = addr_s[sel_s];
                    used_s         = 2'd1;
                end else if ((used_s == 2'd1) && (addr_s[sel_s] != first_addr_s)) begin
                    grant_s[sel_s] = 1'b1;
                    nxt_en_d_s     = 1'b1;
                    nxt_addr_d_s   = addr_s[sel_s];
                    nxt_data_d_s   = data_s[sel_s];
                    used_s         = 2'd2;
                end else begin
                    grant_s[sel_s] = 1'b0;
                end
            end
        end else begin
            grant_s = 3'b000;
        end
    end

    assign bus.ld_ready  = grant_s[0];
    assign bus.alu_ready = grant_s[1];
    assign bus.md_ready  = grant_s[2];

    // Starvation counter: counts stalled mul/div cycles, saturating at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_r <= 4'd0;
        end else if (!bus.md_valid || grant_s[2]) begin
            starve_r <= 4'd0;
        end else if (starve_r != LIMIT_C) begin
            starve_r <= starve_r + 4'd1;
        end else begin
            starve_r <= starve_r;
        end
    end

    // Write-port registers; an idle port carries zero address and data.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_c_r   <= 1'b0;
            addr_c_r <= 5'd0;
            data_c_r <= 32'd0;
            en_d_r   <= 1'b0;
            addr_d_r <= 5'd0;
            data_d_r <= 32'd0;
        end else begin
            en_c_r   <= nxt_en_c_s;
            addr_c_r <= nxt_addr_c_s;
            data_c_r <= nxt_data_c_s;
            en_d_r   <= nxt_en_d_s;
            addr_d_r <= nxt_addr_d_s;
            data_d_r <= nxt_data_d_s;
        end
    end

    assign bus.write_enable_c = en_c_r;
    assign bus.write_addr_c   = addr_c_r;
    assign bus.write_data_c   = data_c_r;
    assign bus.write_enable_d = en_d_r;
    assign bus.write_addr_d   = addr_d_r;
    assign bus.write_data_d   = data_d_r;

    // Pending mask: every valid request plus every write currently on a port.
    // Register 0 is never reported.
    always_comb begin
        mask_s = 32'd0;
        for (int k = 0; k < 3; k++) begin
            mask_s = mask_s | ({31'd0, vld_s[k]} << addr_s[k]);
        end
        mask_s = mask_s | ({31'd0, en_c_r} << addr_c_r);
        mask_s = mask_s | ({31'd0, en_d_r} << addr_d_r);
        if (reset) begin
            mask_s = 32'd0;
        end else begin
            mask_s[0] = 1'b0;
        end
    end

    assign bus.pending_mask = mask_s;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Self-checking bench for regfile_writeback_arbiter: directed scenarios
// followed by randomized traffic, all checked against a behavioural model.
module tb_regfile_writeback_arbiter;

    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_writeback_arbiter_if bus ();

    regfile_writeback_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Requester drive state (0 = ld, 1 = alu, 2 = md)
    logic        v [3];
    logic [4:0]  a [3];
    logic [31:0] d [3];

    assign bus.ld_valid  = v[0];
    assign bus.ld_addr   = a[0];
    assign bus.ld_data   = d[0];
    assign bus.alu_valid = v[1];
    assign bus.alu_addr  = a[1];
    assign bus.alu_data  = d[1];
    assign bus.md_valid  = v[2];
    assign bus.md_addr   = a[2];
    assign bus.md_data   = d[2];

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit          m_known = 1'b0;
    bit          m_en   [2];
    logic [4:0]  m_addr [2];
    logic [31:0] m_data [2];
    int          m_starve = 0;
    bit          exp_rdy [3];
    bit          n_en   [2];
    logic [4:0]  n_addr [2];
    logic [31:0] n_data [2];
    logic [31:0] exp_pm;
    logic        obs_rdy [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Model: walk requesters in priority order, collecting up to two
    // distinct nonzero destinations; address 0 is acked for free.
    task automatic model_eval();
        int order [3];
        int taken [$];
        if (m_starve == LIMIT) order = '{2, 0, 1};
        else                   order = '{0, 1, 2};
        n_en    = '{1'b0, 1'b0};
        n_addr  = '{5'd0, 5'd0};
        n_data  = '{32'd0, 32'd0};
        exp_rdy = '{1'b0, 1'b0, 1'b0};
        if (!reset) begin
            for (int k = 0; k < 3; k++) begin
                int r;
                bit clash;
                r = order[k];
                clash = 1'b0;
                if (!v[r]) continue;
                if (a[r] == 5'd0) begin
                    exp_rdy[r] = 1'b1;
                    continue;
                end
                foreach (taken[j]) if (taken[j] == int'(a[r])) clash = 1'b1;
                if (taken.size() < 2 && !clash) begin
                    exp_rdy[r] = 1'b1;
                    n_en[taken.size()]   = 1'b1;
                    n_addr[taken.size()] = a[r];
                    n_data[taken.size()] = d[r];
                    taken.push_back(int'(a[r]));
                end
            end
        end
        exp_pm = 32'd0;
        if (!reset) begin
            for (int r = 0; r < 3; r++) if (v[r]) exp_pm[a[r]] = 1'b1;
            for (int p = 0; p < 2; p++) if (m_en[p]) exp_pm[m_addr[p]] = 1'b1;
            exp_pm[0] = 1'b0;
        end
    endtask

    // One clock cycle: check at the falling edge, advance the model at the
    // rising edge, return 1 time unit later so the caller can drive inputs.
    task automatic tick();
        @(negedge clk);
        model_eval();
        obs_rdy[0] = bus.ld_ready;
        obs_rdy[1] = bus.alu_ready;
        obs_rdy[2] = bus.md_ready;
        chk("ld_ready",  {31'd0, bus.ld_ready},  {31'd0, exp_rdy[0]});
        chk("alu_ready", {31'd0, bus.alu_ready}, {31'd0, exp_rdy[1]});
        chk("md_ready",  {31'd0, bus.md_ready},  {31'd0, exp_rdy[2]});
        chk("pending_mask", bus.pending_mask, exp_pm);
        if (m_known) begin
            chk("en_c",   {31'd0, bus.write_enable_c}, {31'd0, m_en[0]});
            chk("addr_c", {27'd0, bus.write_addr_c},   {27'd0, m_addr[0]});
            chk("data_c", bus.write_data_c,            m_data[0]);
            chk("en_d",   {31'd0, bus.write_enable_d}, {31'd0, m_en[1]});
            chk("addr_d", {27'd0, bus.write_addr_d},   {27'd0, m_addr[1]});
            chk("data_d", bus.write_data_d,            m_data[1]);
            if (bus.write_enable_c && bus.write_enable_d)
                chk("c_d_distinct", {31'd0, bus.write_addr_c == bus.write_addr_d}, 32'd0);
        end
        @(posedge clk);
        if (reset) begin
            m_en     = '{1'b0, 1'b0};
            m_addr   = '{5'd0, 5'd0};
            m_data   = '{32'd0, 32'd0};
            m_starve = 0;
        end else begin
            m_en   = n_en;
            m_addr = n_addr;
            m_data = n_data;
            if (!v[2] || exp_rdy[2]) m_starve = 0;
            else if (m_starve < LIMIT) m_starve++;
        end
        m_known = 1'b1;
        #1;
    endtask

    task automatic set_req(input int r, input logic vv, input logic [4:0] aa, input logic [31:0] dd);
        v[r] = vv;
        a[r] = aa;
        d[r] = dd;
    endtask

    initial begin
        logic [31:0] ld_data_t4;
        logic [4:0]  ld_addr_t4;

        // 1: reset with all requesters valid
        reset = 1'b1;
        set_req(0, 1'b1, 5'd1, 32'h1);
        set_req(1, 1'b1, 5'd2, 32'h2);
        set_req(2, 1'b1, 5'd3, 32'h3);
        tick();
        tick();
        chk("t1_en_c", {31'd0, bus.write_enable_c}, 32'd0);
        chk("t1_en_d", {31'd0, bus.write_enable_d}, 32'd0);
        reset = 1'b0;

        // 2: three valid, two ports
        set_req(0, 1'b1, 5'd8,  32'h11);
        set_req(1, 1'b1, 5'd9,  32'h22);
        set_req(2, 1'b1, 5'd10, 32'h33);
        tick();
        chk("t2_md_stalled", {31'd0, obs_rdy[2]}, 32'd0);
        chk("t2_addr_c", {27'd0, bus.write_addr_c}, 32'd8);
        chk("t2_data_c", bus.write_data_c, 32'h11);
        chk("t2_addr_d", {27'd0, bus.write_addr_d}, 32'd9);
        chk("t2_data_d", bus.write_data_d, 32'h22);
        chk("t2_pending", bus.pending_mask & 32'h0000_0700, 32'h0000_0700);
        v[0] = 1'b0;
        v[1] = 1'b0;
        tick();
        v[2] = 1'b0;
        tick();

        // 3: same-register collision between ld and alu
        set_req(0, 1'b1, 5'd5, 32'hAA);
        set_req(1, 1'b1, 5'd5, 32'hBB);
        tick();
        chk("t3_alu_blocked", {31'd0, obs_rdy[1]}, 32'd0);
        chk("t3_c_ld", {bus.write_addr_c, bus.write_data_c[26:0]}, {5'd5, 27'hAA});
        chk("t3_d_idle", {31'd0, bus.write_enable_d}, 32'd0);
        v[0] = 1'b0;
        tick();
        chk("t3_c_alu", {bus.write_addr_c, bus.write_data_c[26:0]}, {5'd5, 27'hBB});
        v[1] = 1'b0;
        tick();

        // 4: mul/div starvation relief
        set_req(2, 1'b1, 5'd3, 32'h77);
        ld_addr_t4 = 5'd0;
        ld_data_t4 = 32'd0;
        for (int i = 0; i < 5; i++) begin
            ld_addr_t4 = 5'(16 + i);
            ld_data_t4 = $urandom;
            set_req(0, 1'b1, ld_addr_t4, ld_data_t4);
            set_req(1, 1'b1, 5'(24 + i), $urandom);
            tick();
            chk("t4_md_ready", {31'd0, obs_rdy[2]}, (i == 4) ? 32'd1 : 32'd0);
        end
        chk("t4_c_md", {bus.write_addr_c, bus.write_data_c[26:0]}, {5'd3, 27'h77});
        chk("t4_d_ld_addr", {27'd0, bus.write_addr_d}, {27'd0, ld_addr_t4});
        chk("t4_d_ld_data", bus.write_data_d, ld_data_t4);
        v[0] = 1'b0;
        v[1] = 1'b0;
        v[2] = 1'b0;
        tick();

        // 5: write to register 0 takes no port
        set_req(0, 1'b1, 5'd4, 32'h4444);
        set_req(1, 1'b1, 5'd0, 32'hDEADBEEF);
        tick();
        chk("t5_both_ready", {30'd0, obs_rdy[0], obs_rdy[1]}, 32'd3);
        chk("t5_c", {bus.write_addr_c, bus.write_data_c[26:0]}, {5'd4, 27'h4444});
        chk("t5_d_idle", {31'd0, bus.write_enable_d}, 32'd0);
        chk("t5_pm_bit0", {31'd0, bus.pending_mask[0]}, 32'd0);
        v[0] = 1'b0;
        v[1] = 1'b0;
        tick();

        // 6: reset right after acceptance
        set_req(0, 1'b1, 5'd7,  32'h7777);
        set_req(1, 1'b1, 5'd12, 32'hCCCC);
        tick();
        v[0] = 1'b0;
        v[1] = 1'b0;
        reset = 1'b1;
        tick();
        chk("t6_en_c", {31'd0, bus.write_enable_c}, 32'd0);
        chk("t6_en_d", {31'd0, bus.write_enable_d}, 32'd0);
        reset = 1'b0;
        tick();

        // Randomized traffic with small address range to force collisions
        for (int n = 0; n < 3000; n++) begin
            for (int r = 0; r < 3; r++) begin
                if (v[r] && exp_rdy[r]) begin
                    if ($urandom_range(0, 3) != 0) set_req(r, 1'b1, 5'($urandom_range(0, 7)), $urandom);
                    else v[r] = 1'b0;
                end else if (v[r]) begin
                    if ($urandom_range(0, 19) == 0) v[r] = 1'b0;
                end else if ($urandom_range(0, 3) != 0) begin
                    set_req(r, 1'b1, 5'($urandom_range(0, 7)), $urandom);
                end
            end
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
